muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Iterative multi-cycle execution unit for RV32M, in the EX stage beside the ALU.
- Accepts a mul/div/rem request selected by Funct3 when the instruction carries Funct7 = 0000001.
- Runs a shift-add multiplier or restoring divider over DATA_WIDTH cycles and stalls the pipeline until the result is ready.
- The ALU keeps handling all base-ISA operations; this block only sequences M-extension operations.

Parameters:
- DATA_WIDTH, 32, operand and result width; the iteration counter is $clog2(DATA_WIDTH)+1 bits.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request valid; EX instruction is an M-op
- Funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- SrcA  input  DATA_WIDTH  rs1 operand (multiplicand / dividend)
- SrcB  input  DATA_WIDTH  rs2 operand (multiplier / divisor)
- flush  input  1  abort the current operation (branch taken / exception)
- stall  output  1  hold IF/ID/EX registers
- busy  output  1  operation in progress
- done  output  1  one-cycle result-valid pulse
- Result  output  DATA_WIDTH  operation result, held until the next accept

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy=0; done=0; Result=0; counter and internal registers cleared.
- FSM states: IDLE, CALC, DONE.
- IDLE, start=1, flush=0: accept the request.
  - Latch Funct3 and the operand magnitudes.
  - Signed ops take the absolute value of signed operands; MULHSU treats only SrcA as signed.
  - Latch the result-sign flags.
  - Go to CALC with counter=0, or go directly to DONE for a division special case.
- CALC: one iteration per cycle.
  - Multiply: if multiplier bit is 1, add multiplicand to the 2W accumulator, then shift.
  - Divide: restoring shift-subtract on magnitudes.
  - When counter = DATA_WIDTH-1, go to DONE.
- DONE: done=1 for exactly one cycle; Result is registered on entry to DONE; return to IDLE.
- Result selection:
  - MUL: low W bits of the product.
  - MULH/MULHSU/MULHU: high W bits of the product.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- Sign correction is applied in the last CALC cycle:
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the dividend's sign.
- Division special cases (detected at accept, 1-cycle path IDLE→DONE):
  - Divisor 0: quotient = all ones; remainder = SrcA.
  - Signed overflow (SrcA = 0x80000000, SrcB = -1, DIV/REM only): quotient = 0x80000000; remainder = 0.
- Latency:
  - Normal: accept at edge N, done high in cycle N+DATA_WIDTH+1 (33 for W=32).
  - Special case: done high in cycle N+1.
- stall = (state==IDLE && start && !flush) || state==CALC.
  - stall=0 in DONE, so the pipeline advances with Result on the edge ending DONE.
- busy = 1 in CALC and DONE.
- start is ignored in CALC and DONE; no queueing. A request arriving in the cycle after DONE is accepted normally.
- flush: synchronous, highest priority below reset.
  - Any state → IDLE at the next edge.
  - done is not asserted; Result keeps its previous value.
  - flush together with start in IDLE: no accept.
- Operand changes after accept have no effect (all operands are latched).

Optional Feature:
- Macro: MULDIV_SINGLE_CYCLE_MUL_EN.
- Defined: MUL/MULH/MULHSU/MULHU compute the product combinationally using a 2W-bit signed/unsigned multiply at accept.
  - Path is IDLE→DONE; done high in cycle N+1.
  - Division is unchanged (iterative).
- Undefined: all multiplies use the iterative CALC path with DATA_WIDTH+1 cycle latency; no multiplier operator is inferred.

Test Plan:
- MUL, SrcA=7, SrcB=-3 (0xFFFFFFFD) → stall high from accept through CALC; done pulses exactly 33 cycles after accept; Result=0xFFFFFFEB.
- MULHU, SrcA=0xFFFFFFFF, SrcB=0xFFFFFFFF → Result=0xFFFFFFFE; MULH same operands → Result=0x00000000; MULHSU → Result=0xFFFFFFFF.
- DIV -20/6 → Result=0xFFFFFFFD (-3); REM same → Result=0xFFFFFFFE (-2); DIVU 20/6 → 3; REMU → 2.
- DIVU 5/0 → done at N+1, Result=0xFFFFFFFF; REM 5/0 → Result=5; DIV 0x80000000/-1 → Result=0x80000000; REM same → Result=0.
- flush asserted in CALC iteration 10 → next cycle IDLE, busy=0, stall=0, no done pulse, Result unchanged; a new start the cycle after completes correctly.
- reset asserted mid-CALC, asynchronously between edges → busy, done, stall and Result go to 0 immediately; with MULDIV_SINGLE_CYCLE_MUL_EN defined, MUL 6×7 → done at N+1, Result=42.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer (shift-add multiplier, restoring divider).
// Optional macro MULDIV_SINGLE_CYCLE_MUL_EN: multiplies complete in one cycle via a combinational product.
module muldiv_sequencer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            Funct3,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    input  logic                  flush,
    output logic                  stall,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] Result
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {IDLE = 2'b00, CALC = 2'b01, DONE = 2'b10} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [W-1:0]    opb_q, opb_d;
    logic            neg_res_q, neg_res_d;
    logic            neg_rem_q, neg_rem_d;
    logic [W-1:0]    result_q, result_d;

    logic            signed_a_s, signed_b_s, neg_a_s, neg_b_s;
    logic [W-1:0]    a_mag_s, b_mag_s;
    logic            div_zero_s, div_ovf_s;
    logic [W:0]      add_s, shift_s, diff_s;
    logic [2*W-1:0]  mul_next_s, div_next_s, step_s, prod_s;
    logic [W-1:0]    quo_s, rem_s, final_s;
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
    logic [2*W-1:0]  a_ext_s, b_ext_s, fast_prod_s;
`endif

    // Operand decode, magnitudes and division special-case detection at accept
    always_comb begin
        signed_a_s = (Funct3 == 3'b001) || (Funct3 == 3'b010) ||
                     (Funct3 == 3'b100) || (Funct3 == 3'b110);
        signed_b_s = (Funct3 == 3'b001) || (Funct3 == 3'b100) || (Funct3 == 3'b110);
        neg_a_s    = signed_a_s && SrcA[W-1];
        neg_b_s    = signed_b_s && SrcB[W-1];
        a_mag_s    = neg_a_s ? ({W{1'b0}} - SrcA) : SrcA;
        b_mag_s    = neg_b_s ? ({W{1'b0}} - SrcB) : SrcB;
        div_zero_s = (SrcB == {W{1'b0}});
        div_ovf_s  = ((Funct3 == 3'b100) || (Funct3 == 3'b110)) &&
                     (SrcA == {1'b1, {(W-1){1'b0}}}) && (SrcB == {W{1'b1}});
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
        a_ext_s     = signed_a_s ? {{W{SrcA[W-1]}}, SrcA} : {{W{1'b0}}, SrcA};
        b_ext_s     = signed_b_s ? {{W{SrcB[W-1]}}, SrcB} : {{W{1'b0}}, SrcB};
        fast_prod_s = a_ext_s * b_ext_s;
`endif
    end

    // One multiply or divide iteration plus sign-corrected result of the final step
    always_comb begin
        add_s      = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
        mul_next_s = {add_s, acc_q[W-1:1]};
        shift_s    = {acc_q[2*W-1:W], acc_q[W-1]};
        diff_s     = shift_s - {1'b0, opb_q};
        if (diff_s[W]) begin
            div_next_s = {shift_s[W-1:0], acc_q[W-2:0], 1'b0};
        end else begin
            div_next_s = {diff_s[W-1:0], acc_q[W-2:0], 1'b1};
        end
        step_s = op_q[2] ? div_next_s : mul_next_s;
        prod_s = neg_res_q ? ({(2*W){1'b0}} - step_s) : step_s;
        quo_s  = neg_res_q ? ({W{1'b0}} - step_s[W-1:0]) : step_s[W-1:0];
        rem_s  = neg_rem_q ? ({W{1'b0}} - step_s[2*W-1:W]) : step_s[2*W-1:W];
        case (op_q)
            3'b000:                 final_s = prod_s[W-1:0];
            3'b001, 3'b010, 3'b011: final_s = prod_s[2*W-1:W];
            3'b100, 3'b101:         final_s = quo_s;
            3'b110, 3'b111:         final_s = rem_s;
            default:                final_s = {W{1'b0}};
        endcase
    end

    // Next-state logic; flush overrides everything and keeps Result untouched
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = {CW{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_d      = Funct3;
                        cnt_d     = {CW{1'b0}};
                        neg_res_d = neg_a_s ^ neg_b_s;
                        neg_rem_d = neg_a_s;
                        if (Funct3[2]) begin
                            if (div_zero_s) begin
                                result_d = Funct3[1] ? SrcA : {W{1'b1}};
                                state_d  = DONE;
                            end else if (div_ovf_s) begin
                                result_d = Funct3[1] ? {W{1'b0}} : {1'b1, {(W-1){1'b0}}};
                                state_d  = DONE;
                            end else begin
                                acc_d   = {{W{1'b0}}, a_mag_s};
                                opb_d   = b_mag_s;
                                state_d = CALC;
                            end
                        end else begin
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
                            result_d = (Funct3 == 3'b000) ? fast_prod_s[W-1:0] : fast_prod_s[2*W-1:W];
                            state_d  = DONE;
`else
                            acc_d   = {{W{1'b0}}, b_mag_s};
                            opb_d   = a_mag_s;
                            state_d = CALC;
`endif
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                CALC: begin
                    acc_d = step_s;
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_q == CW'(W - 1)) begin
                        result_d = final_s;
                        state_d  = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= {CW{1'b0}};
            op_q      <= 3'b000;
            acc_q     <= {(2*W){1'b0}};
            opb_q     <= {W{1'b0}};
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= {W{1'b0}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    assign stall  = ((state_q == IDLE) && start && !flush) || (state_q == CALC);
    assign busy   = (state_q == CALC) || (state_q == DONE);
    assign done   = (state_q == DONE);
    assign Result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed vectors push expectations, a monitor checks each done pulse.
module tb_muldiv_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  Funct3 = 3'b000;
    logic [31:0] SrcA = 32'd0;
    logic [31:0] SrcB = 32'd0;
    logic        flush = 1'b0;
    logic        stall, busy, done;
    logic [31:0] Result;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [31:0] last_res = 32'd0;

`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    muldiv_sequencer #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .Funct3(Funct3),
        .SrcA(SrcA), .SrcB(SrcB), .flush(flush),
        .stall(stall), .busy(busy), .done(done), .Result(Result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation in result and latency
    always @(negedge clk) begin
        exp_t e;
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("result", Result, e.res);
                chk("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
                chk("stall_in_done", {31'd0, stall}, 32'd0);
            end
        end else if (!reset && busy) begin
            chk("stall_in_calc", {31'd0, stall}, 32'd1);
        end
    end

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expv, input int lat, input bit push);
        int guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk("idle_timeout", 32'(guard), 32'd0);
        Funct3 = f;
        SrcA   = a;
        SrcB   = b;
        start  = 1'b1;
        if (push) begin
            e.res = expv; e.lat = lat; e.acc_cyc = cyc;
            exp_q.push_back(e);
            last_res = expv;
        end
        @(posedge clk);
        #1;
        start  = 1'b0;
        SrcA   = $urandom;
        SrcB   = $urandom;
        Funct3 = 3'($urandom_range(0, 7));
    endtask

    initial begin
        int guard;
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_result", Result, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, 1'b1);
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, 1'b1);
        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT, 1'b1);
        issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 1'b1);
        issue(3'b000, 32'd6, 32'd7, 32'd42, MUL_LAT, 1'b1);
        issue(3'b100, 32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFD, DIV_LAT, 1'b1);
        issue(3'b110, 32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFE, DIV_LAT, 1'b1);
        issue(3'b101, 32'd20, 32'd6, 32'd3, DIV_LAT, 1'b1);
        issue(3'b111, 32'd20, 32'd6, 32'd2, DIV_LAT, 1'b1);
        issue(3'b101, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, DIV_LAT, 1'b1);
        issue(3'b111, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, DIV_LAT, 1'b1);
        issue(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b1);
        issue(3'b110, 32'd5, 32'd0, 32'd5, 1, 1'b1);
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b1);
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 1'b1);

        // Flush in CALC iteration 10: no done, Result keeps the last completed value
        issue(3'b101, 32'd1000, 32'd7, 32'd0, 0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_stall", {31'd0, stall}, 32'd0);
        chk("flush_done", {31'd0, done}, 32'd0);
        chk("flush_result", Result, last_res);
        issue(3'b100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, DIV_LAT, 1'b1);

        // Asynchronous reset between edges during a long operation
        issue(3'b101, 32'd12345, 32'd11, 32'd0, 0, 1'b0);
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("areset_busy", {31'd0, busy}, 32'd0);
        chk("areset_done", {31'd0, done}, 32'd0);
        chk("areset_stall", {31'd0, stall}, 32'd0);
        chk("areset_result", Result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        issue(3'b000, 32'd6, 32'd7, 32'd42, MUL_LAT, 1'b1);
        issue(3'b011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, MUL_LAT, 1'b1);

        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
